// File: rtl/axi_burst_cfgreg_bridge_if.sv
// AXI4 slave-side bus bundle for the config-register bridge: AW/W/B/AR/R channels.
interface axi_burst_cfgreg_bridge_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4
);
  // Write address channel
  logic                    awvalid;
  logic                    awready;
  logic [31:0]             awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  // Write data channel
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  // Write response channel
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic [ID_WIDTH-1:0]     bid;
  // Read address channel
  logic                    arvalid;
  logic                    arready;
  logic [31:0]             araddr;
  logic [ID_WIDTH-1:0]     arid;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  // Read data channel
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic [ID_WIDTH-1:0]     rid;
  logic                    rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );
endinterface

// File: rtl/axi_burst_cfgreg_bridge.sv
// AXI4 slave to config-register bridge: INCR/FIXED bursts, byte strobes,
// alternating read/write arbitration, SLVERR for bad bursts and out-of-window beats.
package axi_burst_cfgreg_bridge_pkg;
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
endpackage

module axi_burst_cfgreg_bridge
  import axi_burst_cfgreg_bridge_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int CFG_ADDR_WIDTH = 12,
  parameter int NUM_REGS       = 32
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  axi_burst_cfgreg_bridge_if.slave    axi,
  output logic [CFG_ADDR_WIDTH-1:0]   config_offset_o,
  output logic                        config_wen_o,
  output logic [AXI_DATA_WIDTH/8-1:0] config_wstrb_o,
  output logic [AXI_DATA_WIDTH-1:0]   config_wdata_o,
  output logic                        config_ren_o,
  input  logic [AXI_DATA_WIDTH-1:0]   config_rdata_i
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam logic [CFG_ADDR_WIDTH-1:0] BEAT_STEP  = CFG_ADDR_WIDTH'(BYTES);
  localparam logic [CFG_ADDR_WIDTH-1:0] ALIGN_MASK = CFG_ADDR_WIDTH'(BYTES - 1);
  // One extra bit so a window covering the whole offset space still compares correctly.
  localparam logic [CFG_ADDR_WIDTH:0]   WINDOW_END = (CFG_ADDR_WIDTH + 1)'(NUM_REGS * BYTES);

  typedef enum logic [1:0] {IDLE, RBURST, WBURST, WRESP} state_t;

  state_t                    state;
  logic                      rd_prio;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [CFG_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic [1:0]                burst_q;
  logic                      err_q;

  logic rd_grant, wr_grant, in_range, burst_ok, beat_ok, last_beat, w_beat;

  // Upper AXI address bits fall outside the config window and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi.awaddr[31:CFG_ADDR_WIDTH], axi.araddr[31:CFG_ADDR_WIDTH]};

  function automatic logic [CFG_ADDR_WIDTH-1:0] align(input logic [CFG_ADDR_WIDTH-1:0] a);
    return a & ~ALIGN_MASK;
  endfunction

  assign in_range  = {1'b0, addr_q} < WINDOW_END;
  assign burst_ok  = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR);
  assign beat_ok   = in_range && burst_ok;
  assign last_beat = (beat_q == len_q);

  // Fair arbitration: rd_prio picks the winner only when both address channels request.
  assign rd_grant = (state == IDLE) && axi.arvalid && (!axi.awvalid || rd_prio);
  assign wr_grant = (state == IDLE) && axi.awvalid && (!axi.arvalid || !rd_prio);

  assign axi.arready = rd_grant;
  assign axi.awready = wr_grant;
  assign axi.rvalid  = (state == RBURST);
  assign axi.wready  = (state == WBURST);
  assign axi.bvalid  = (state == WRESP);

  assign axi.rdata = (axi.rvalid && beat_ok) ? config_rdata_i : '0;
  assign axi.rresp = (axi.rvalid && !beat_ok) ? RESP_SLVERR : RESP_OKAY;
  assign axi.rlast = axi.rvalid && last_beat;
  assign axi.rid   = id_q;
  assign axi.bresp = (axi.bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi.bid   = id_q;

  assign w_beat          = axi.wvalid && axi.wready;
  assign config_offset_o = addr_q;
  assign config_wen_o    = w_beat && beat_ok && (|axi.wstrb);
  assign config_wstrb_o  = config_wen_o ? axi.wstrb : '0;
  assign config_wdata_o  = config_wen_o ? axi.wdata : '0;
  assign config_ren_o    = axi.rvalid && axi.rready && beat_ok;

  // Transaction FSM: address grant, beat stepping, sticky write error, response hand-off.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      rd_prio <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= BURST_INCR;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          err_q  <= 1'b0;
          beat_q <= '0;
          if (rd_grant) begin
            state   <= RBURST;
            rd_prio <= 1'b0;
            id_q    <= axi.arid;
            addr_q  <= align(axi.araddr[CFG_ADDR_WIDTH-1:0]);
            len_q   <= axi.arlen;
            burst_q <= axi.arburst;
          end else if (wr_grant) begin
            state   <= WBURST;
            rd_prio <= 1'b1;
            id_q    <= axi.awid;
            addr_q  <= align(axi.awaddr[CFG_ADDR_WIDTH-1:0]);
            len_q   <= axi.awlen;
            burst_q <= axi.awburst;
          end
        end
        RBURST: begin
          if (axi.rready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
              if (burst_q == BURST_INCR) addr_q <= addr_q + BEAT_STEP;
            end
          end
        end
        WBURST: begin
          if (axi.wvalid) begin
            // Early wlast, missing wlast, bad burst type or out-of-window beat all poison the burst.
            if ((axi.wlast != last_beat) || !beat_ok) err_q <= 1'b1;
            if (last_beat || axi.wlast) begin
              state <= WRESP;
            end else begin
              beat_q <= beat_q + 8'd1;
              if (burst_q == BURST_INCR) addr_q <= addr_q + BEAT_STEP;
            end
          end
        end
        WRESP: begin
          if (axi.bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
